// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1 32-bit mux-fronted resource
//   among four requesters. It drives the mux select and a one-hot grant, and
//   holds a grant across a multi-cycle transaction. The grant ends when the
//   resource signals Done, when the granted requester drops its request, or
//   when the hold limit is reached.
//
// Parameters
//   MAX_HOLD : maximum cycles a single grant may be held (>= 2)
//   CNT_W    : hold-counter width, 2**CNT_W >= MAX_HOLD
//
// Ports
//   Clk      in   1  clock, rising edge
//   Rst      in   1  asynchronous reset, active-low
//   Req      in   4  request per requester (Req[i] feeds mux input i)
//   Done     in   1  resource finished current transaction
//   Sel      out  2  registered mux select (index of granted requester)
//   Gnt      out  4  registered one-hot grant, 0000 when idle
//   GntValid out  1  registered, high while any grant is active
//   Timeout  out  1  registered 1-cycle pulse: grant revoked by hold limit
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic       Done,
  output logic [1:0] Sel,
  output logic [3:0] Gnt,
  output logic       GntValid,
  output logic       Timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [1:0]       sel_q,     sel_d;
  logic [3:0]       gnt_q,     gnt_d;
  logic             valid_q,   valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       last_q,    last_d;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_HOLD - 1);

  // Search Last+1, Last+2, Last+3, Last (mod 4) for the first set request.
  // The 2-bit add wraps naturally; k=4 lands back on Last, so the most
  // recently served requester only wins when nobody else is asking.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  logic [1:0] pick;
  assign pick = rr_pick(Req, last_q);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;

    unique case (state_q)
      IDLE: begin
        // Sel is left alone while idle so the mux output stays stable.
        if (Req != 4'b0000) begin
          sel_d   = pick;
          gnt_d   = 4'b0001 << pick;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (Done || !Req[sel_q] || (cnt_q == CntLast)) begin
          // Done beats an abandoned request, which beats the hold limit;
          // only a pure hold-limit release raises Timeout.
          timeout_d = !Done && Req[sel_q];
          gnt_d     = 4'b0000;
          valid_d   = 1'b0;
          last_d    = sel_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      sel_q     <= 2'b00;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign Sel      = sel_q;
  assign Gnt      = gnt_q;
  assign GntValid = valid_q;
  assign Timeout  = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter, built with MAX_HOLD=4 so the hold
//   limit is reachable in a few cycles. Outputs are sampled 1 time unit after
//   the rising edge; inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       Clk;
  logic       Rst;
  logic [3:0] Req;
  logic       Done;
  logic [1:0] Sel;
  logic [3:0] Gnt;
  logic       GntValid;
  logic       Timeout;

  int n_chk;
  int n_fail;

  mux4_rr_arbiter #(
    .MAX_HOLD(4),
    .CNT_W   (2)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Req     (Req),
    .Done    (Done),
    .Sel     (Sel),
    .Gnt     (Gnt),
    .GntValid(GntValid),
    .Timeout (Timeout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Observed outputs packed as {Gnt, Sel, GntValid, Timeout}.
  logic [7:0] obs;
  assign obs = {Gnt, Sel, GntValid, Timeout};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    #1;
    Rst = 1'b1;
    Req  = 4'b0000;
    Done = 1'b0;
  endtask

  task automatic test_reset();
    Rst  = 1'b0;
    Req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      Done = i[0];
      tick();
      n_chk++;
      if (obs !== 8'b0000_00_0_0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got {Gnt,Sel,Vld,TO}=%b, want 00000000", i, obs);
      end
    end
    Rst  = 1'b1;
    Req  = 4'b0000;
    Done = 1'b0;
  endtask

  task automatic test_single_done();
    Req = 4'b0100;
    tick();
    n_chk++;
    if (obs !== 8'b0100_10_1_0) begin
      n_fail++;
      $display("FAIL single_grant: got %b, want 01001010", obs);
    end
    Done = 1'b1;
    tick();
    n_chk++;
    if (obs !== 8'b0000_10_0_0) begin
      n_fail++;
      $display("FAIL done_release: got %b, want 00001000", obs);
    end
    Done = 1'b0;
    Req  = 4'b0000;
    tick();
    n_chk++;
    if (obs !== 8'b0000_10_0_0) begin
      n_fail++;
      $display("FAIL idle_sel_kept: got %b, want 00001000", obs);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel [5];
    logic [1:0] s;
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    Req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      s = exp_sel[i];
      tick();
      n_chk++;
      if (obs !== {4'b0001 << s, s, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b, want %b", i, obs, {4'b0001 << s, s, 1'b1, 1'b0});
      end
      Done = 1'b1;
      tick();
      n_chk++;
      if (obs !== {4'b0000, s, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL rr_bubble[%0d]: got %b, want %b", i, obs, {4'b0000, s, 1'b0, 1'b0});
      end
      Done = 1'b0;
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    Req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (obs !== 8'b0001_00_1_0) begin
        n_fail++;
        $display("FAIL hold_cycle[%0d]: got %b, want 00010010", i, obs);
      end
    end
    tick();
    n_chk++;
    if (obs !== 8'b0000_00_0_1) begin
      n_fail++;
      $display("FAIL timeout_release: got %b, want 00000001", obs);
    end
    tick();
    n_chk++;
    if (obs !== 8'b0001_00_1_0) begin
      n_fail++;
      $display("FAIL timeout_regrant: got %b, want 00010010", obs);
    end
    Req  = 4'b0000;
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  task automatic test_done_priority();
    do_reset();
    Req = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    Done = 1'b1;
    tick();
    n_chk++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL done_on_limit: got %b, want 00000000", obs);
    end
    Done = 1'b0;
    Req  = 4'b0000;
    tick();
  endtask

  task automatic test_drop();
    // Last is 0 here, so requester 1 wins next.
    Req = 4'b0010;
    tick();
    n_chk++;
    if (obs !== 8'b0010_01_1_0) begin
      n_fail++;
      $display("FAIL drop_grant: got %b, want 00100110", obs);
    end
    Req = 4'b1000;
    tick();
    n_chk++;
    if (obs !== 8'b0000_01_0_0) begin
      n_fail++;
      $display("FAIL drop_release: got %b, want 00000100", obs);
    end
    tick();
    n_chk++;
    if (obs !== 8'b1000_11_1_0) begin
      n_fail++;
      $display("FAIL drop_next: got %b, want 10001110", obs);
    end
    Req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    // Last is 3 here, so requester 2 is granted directly.
    Req = 4'b0100;
    tick();
    n_chk++;
    if (obs !== 8'b0100_10_1_0) begin
      n_fail++;
      $display("FAIL pre_reset_grant: got %b, want 01001010", obs);
    end
    #2;
    Rst = 1'b0;
    #1;
    n_chk++;
    if (obs !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL async_clear: got %b, want 00000000", obs);
    end
    Rst = 1'b1;
    Req = 4'b1001;
    tick();
    n_chk++;
    if (obs !== 8'b0001_00_1_0) begin
      n_fail++;
      $display("FAIL post_reset_first: got %b, want 00010010", obs);
    end
    Req = 4'b0000;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Rst    = 1'b1;
    Req    = 4'b0000;
    Done   = 1'b0;
    #1;
    test_reset();
    test_single_done();
    test_round_robin();
    test_timeout();
    test_done_priority();
    test_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
